// File: rtl/qam_demod_if.sv
// qam_demod_if: sample/carrier inputs and symbol decision outputs of the 16-QAM receiver core.
interface qam_demod_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int ACC_WIDTH    = 48
);
  logic                           step;
  logic signed [SAMPLE_WIDTH-1:0] rx_sample;
  logic signed [DATA_WIDTH-1:0]   ref_cos;
  logic signed [DATA_WIDTH-1:0]   ref_sin;
  logic                           sym_sync;
  logic [3:0]                     sym;
  logic                           sym_valid;
  logic signed [ACC_WIDTH-1:0]    acc_i_out;
  logic signed [ACC_WIDTH-1:0]    acc_q_out;
  modport master (output step, rx_sample, ref_cos, ref_sin, sym_sync,
                  input  sym, sym_valid, acc_i_out, acc_q_out);
  modport slave  (input  step, rx_sample, ref_cos, ref_sin, sym_sync,
                  output sym, sym_valid, acc_i_out, acc_q_out);
endinterface

// File: rtl/qam_demod.sv
// qam_demod: coherent 16-QAM receiver core; mix, integrate-and-dump over SPS samples, Gray slicer.
module qam_demod #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int PROD_SHIFT   = 30,
  parameter int SPS          = 64,
  parameter int ACC_WIDTH    = 48,
  parameter int THRESH       = 2000
) (
  input logic        clk,
  input logic        rst_n,
  qam_demod_if.slave bus
);
  localparam int PW = SAMPLE_WIDTH + DATA_WIDTH;
  localparam int CW = (SPS > 2) ? $clog2(SPS) : 1;
  localparam logic signed [ACC_WIDTH-1:0] TH = ACC_WIDTH'(THRESH);
  logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
  logic signed [PW-1:0] m_i, m_q;
  logic signed [ACC_WIDTH-1:0] p_i_q, p_i_d, p_q_q, p_q_d, sum_i, sum_q;
  logic signed [ACC_WIDTH-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [ACC_WIDTH-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
  logic v_q, v_d, last_q, last_d, dump_q, dump_d, sv_q, sv_d;
  logic [3:0] sym_q, sym_d;
  function automatic logic [1:0] slice(input logic signed [ACC_WIDTH-1:0] a);
    return a < -TH ? 2'b00 : a < 0 ? 2'b01 : a < TH ? 2'b11 : 2'b10;
  endfunction
  always_comb begin
    m_i     = bus.rx_sample * bus.ref_cos;
    m_q     = bus.rx_sample * bus.ref_sin;
    p_i_d   = m_i >>> PROD_SHIFT;
    p_q_d   = m_q >>> PROD_SHIFT;
    cnt_eff = bus.sym_sync ? '0 : cnt_q;
    v_d     = bus.step;
    last_d  = bus.step && cnt_eff == CW'(SPS - 1);
    cnt_d   = bus.step ? (cnt_eff == CW'(SPS - 1) ? '0 : cnt_eff + 1'b1) : cnt_eff;
    sum_i   = acc_i_q + p_i_q;
    sum_q   = acc_q_q + p_q_q;
    // a pending last product is a dump in flight and survives sym_sync
    dump_d  = v_q && last_q;
    acc_i_d = (bus.sym_sync || dump_d) ? '0 : v_q ? sum_i : acc_i_q;
    acc_q_d = (bus.sym_sync || dump_d) ? '0 : v_q ? sum_q : acc_q_q;
    out_i_d = dump_d ? sum_i : out_i_q;
    out_q_d = dump_d ? sum_q : out_q_q;
    sv_d    = dump_q;
    sym_d   = dump_q ? {slice(out_i_q), slice(out_q_q)} : sym_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      p_i_q   <= '0;
      p_q_q   <= '0;
      v_q     <= 1'b0;
      last_q  <= 1'b0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      out_i_q <= '0;
      out_q_q <= '0;
      dump_q  <= 1'b0;
      sv_q    <= 1'b0;
      sym_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      p_i_q   <= p_i_d;
      p_q_q   <= p_q_d;
      v_q     <= v_d;
      last_q  <= last_d;
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      out_i_q <= out_i_d;
      out_q_q <= out_q_d;
      dump_q  <= dump_d;
      sv_q    <= sv_d;
      sym_q   <= sym_d;
    end
  end
  assign bus.sym       = sym_q;
  assign bus.sym_valid = sv_q;
  assign bus.acc_i_out = out_i_q;
  assign bus.acc_q_out = out_q_q;
endmodule

// File: tb/tb_qam_demod.sv
// tb_qam_demod: directed vectors for qam_demod at SPS=4 with hand-computed symbols and pulse timing.
module tb_qam_demod;
  localparam int ONE = 1073741824;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int t_last = 0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {int c; logic [3:0] s; longint ai; longint aq;} pulse_t;
  pulse_t pq[$];
  qam_demod_if #(.SAMPLE_WIDTH(16), .DATA_WIDTH(32), .ACC_WIDTH(48)) bus_if ();
  qam_demod #(.SPS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus_if.sym_valid === 1'b1)
    pq.push_back('{cyc, bus_if.sym, longint'(bus_if.acc_i_out), longint'(bus_if.acc_q_out)});
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask
  task automatic drive(input bit st, input int rx, input int cs, input int sn, input bit sy);
    bus_if.step      = st;
    bus_if.rx_sample = 16'(rx);
    bus_if.ref_cos   = cs;
    bus_if.ref_sin   = sn;
    bus_if.sym_sync  = sy;
    @(posedge clk);
    #1;
    if (st) t_last = cyc;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask
  task automatic send_sym(input int r0, input int r1, input int r2, input int r3,
                          input int gap, input int cs, input int sn);
    int r[4];
    r = '{r0, r1, r2, r3};
    for (int i = 0; i < 4; i++) begin
      drive(1, r[i], cs, sn, 0);
      repeat (gap) drive(0, 0, cs, sn, 0);
    end
  endtask
  task automatic chk_pulse(input string tag, input int k, input int exp_c,
                           input logic [3:0] es, input longint ei, input longint eq);
    if (k >= pq.size()) begin
      chk($sformatf("%s_present", tag), 64'(pq.size()), 64'(k + 1));
      return;
    end
    chk($sformatf("%s_time", tag), 64'(pq[k].c), 64'(exp_c));
    chk($sformatf("%s_sym", tag), 64'(pq[k].s), 64'(es));
    chk($sformatf("%s_acc_i", tag), pq[k].ai, ei);
    chk($sformatf("%s_acc_q", tag), pq[k].aq, eq);
  endtask
  initial begin
    int t[3];
    longint sums[6] = '{-2001, -2000, -1, 0, 1999, 2000};
    logic [1:0] ci[6] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10};
    logic [1:0] cq[6] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01};
    bus_if.step = 0; bus_if.rx_sample = 0; bus_if.ref_cos = 0; bus_if.ref_sin = 0; bus_if.sym_sync = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sym", 64'(bus_if.sym), 0);
    chk("rst_valid", 64'(bus_if.sym_valid), 0);
    chk("rst_acc_i", 64'(bus_if.acc_i_out), 0);
    chk("rst_acc_q", 64'(bus_if.acc_q_out), 0);
    rst_n = 1'b1;
    idle(2);
    // back-to-back symbols, step every cycle
    pq.delete();
    for (int k = 0; k < 3; k++) begin
      send_sym(1000, 1000, 1000, 1000, 0, ONE, 0);
      t[k] = t_last;
    end
    idle(5);
    chk("b2b_count", 64'(pq.size()), 3);
    for (int k = 0; k < 3; k++) chk_pulse($sformatf("b2b%0d", k), k, t[k] + 2, 4'b1011, 4000, 0);
    // slicer boundaries; Q arm sees the negated sum
    for (int k = 0; k < 6; k++) begin
      pq.delete();
      send_sym(int'(sums[k]), 0, 0, 0, 0, ONE, -ONE);
      idle(4);
      chk($sformatf("slice%0d_count", k), 64'(pq.size()), 1);
      chk_pulse($sformatf("slice%0d", k), 0, t_last + 2, {ci[k], cq[k]}, sums[k], -sums[k]);
    end
    // step every 3rd cycle
    pq.delete();
    send_sym(1000, 1000, 1000, 1000, 2, ONE, 0);
    t[0] = t_last;
    idle(6);
    chk("gap_count", 64'(pq.size()), 1);
    chk_pulse("gap", 0, t[0] + 2, 4'b1011, 4000, 0);
    // sym_sync discards a partial symbol, including the pending product
    pq.delete();
    drive(1, 3000, ONE, 0, 0);
    drive(1, 3000, ONE, 0, 0);
    drive(0, 0, ONE, 0, 1);
    idle(3);
    chk("sync_partial_count", 64'(pq.size()), 0);
    send_sym(1000, 1000, 1000, 1000, 0, ONE, 0);
    t[0] = t_last;
    idle(4);
    chk("sync_count", 64'(pq.size()), 1);
    chk_pulse("sync", 0, t[0] + 2, 4'b1011, 4000, 0);
    // async reset mid-symbol
    pq.delete();
    drive(1, 3000, ONE, 0, 0);
    drive(1, 3000, ONE, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sym", 64'(bus_if.sym), 0);
    chk("mid_rst_valid", 64'(bus_if.sym_valid), 0);
    chk("mid_rst_acc_i", 64'(bus_if.acc_i_out), 0);
    chk("mid_rst_acc_q", 64'(bus_if.acc_q_out), 0);
    idle(2);
    rst_n = 1'b1;
    send_sym(1000, 1000, 1000, 1000, 0, ONE, 0);
    t[0] = t_last;
    idle(4);
    chk("post_rst_count", 64'(pq.size()), 1);
    chk_pulse("post_rst", 0, t[0] + 2, 4'b1011, 4000, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
